// File: rtl/hex_display_pkg.sv
// hex_display_pkg: seven-segment font, controller states and BCD sizing helper
package hex_display_pkg;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
  // nibbles needed to hold the decimal form of an n-nibble binary value
  function automatic int bcd_digits(input int n);
    return n + n / 4 + 1;
  endfunction
endpackage

// File: rtl/hex_display_ctrl_seg7_encode.sv
// seg7_encode: active-low g..a segment pattern for one hex nibble
module seg7_encode
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = SEG_HEX[nibble];
endmodule

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: N-digit hex/decimal seven-segment driver; define HEX_DISPLAY_BLINK_EN to build per-digit blinking
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_HALF = 25_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    load_dec,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  input  logic                    lzb_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7*NUM_DIGITS-1:0] seg_out,
  output logic [NUM_DIGITS-1:0]   dp_out
);
  localparam int W  = 4 * NUM_DIGITS;
  localparam int B  = bcd_digits(NUM_DIGITS);
  localparam int CW = $clog2(W);

  state_t                  state_q, state_d;
  logic [W-1:0]            shift_q, shift_d;
  logic [4*B-1:0]          bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]           cnt_q;
  logic [W-1:0]            digit_q;
  logic [NUM_DIGITS-1:0]   dp_q, dp_pend;
  logic                    shown_q, ovf_q;
  logic                    hs, in_commit, ovf_c, last_step;
  logic [W-1:0]            v_digits;
  logic [NUM_DIGITS-1:0]   v_dp, hide, dp_d;
  logic                    v_shown, v_ovf, blink_off, run;
  logic [7*NUM_DIGITS-1:0] seg_d;
  logic [6:0]              font [NUM_DIGITS];

  assign load_ready = state_q == IDLE;
  assign hs         = load_valid && load_ready;
  assign in_commit  = state_q == COMMIT;
  assign last_step  = cnt_q == CW'(W - 1);
  assign ovf_c      = |bcd_q[4*B-1:W];

  for (genvar j = 0; j < B; j++) begin : g_adj
    assign bcd_adj[4*j+:4] = bcd_q[4*j+:4] >= 4'd5 ? bcd_q[4*j+:4] + 4'd3 : bcd_q[4*j+:4];
  end

  // next state and one double-dabble step
  always_comb begin
    {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
    state_d = (state_q == IDLE && hs && load_dec) ? CONV :
              (state_q == CONV && last_step)      ? COMMIT :
              in_commit                           ? IDLE : state_q;
  end

  // control state, converter datapath and display registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      digit_q <= '0;
      dp_q    <= '0;
      dp_pend <= '0;
      shown_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hs && !load_dec) begin
        digit_q <= load_value;
        dp_q    <= load_dp;
        shown_q <= 1'b1;
        ovf_q   <= 1'b0;
      end
      if (hs && load_dec) begin
        shift_q <= load_value;
        bcd_q   <= '0;
        cnt_q   <= '0;
        dp_pend <= load_dp;
      end
      if (state_q == CONV) begin
        shift_q <= shift_d;
        bcd_q   <= bcd_d;
        cnt_q   <= cnt_q + 1'b1;
      end
      if (in_commit) begin
        if (!ovf_c) digit_q <= bcd_q[W-1:0];
        dp_q    <= dp_pend;
        ovf_q   <= ovf_c;
        shown_q <= 1'b1;
      end
    end
  end

  // the commit cycle feeds the output stage directly so the result appears with the register write
  assign v_digits = (in_commit && !ovf_c) ? bcd_q[W-1:0] : digit_q;
  assign v_dp     = in_commit ? dp_pend : dp_q;
  assign v_ovf    = in_commit ? ovf_c : ovf_q;
  assign v_shown  = shown_q || in_commit;

`ifdef HEX_DISPLAY_BLINK_EN
  localparam int BW = $clog2(BLINK_HALF + 1);
  logic [BW-1:0] bcnt_q;
  logic          phase_q;
  // blink phase toggles every BLINK_HALF cycles, starting in the on phase
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcnt_q  <= '0;
      phase_q <= 1'b1;
    end else if (bcnt_q == BW'(BLINK_HALF - 1)) begin
      bcnt_q  <= '0;
      phase_q <= ~phase_q;
    end else begin
      bcnt_q  <= bcnt_q + 1'b1;
    end
  end
  assign blink_off = ~phase_q;
`else
  localparam int blink_half_unused = BLINK_HALF;
  assign blink_off = 1'b0;
`endif

  assign hide = {NUM_DIGITS{blink_off}} & blink_mask;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_font
    seg7_encode u_enc (.nibble(v_digits[4*i+:4]), .seg(font[i]));
  end

  // per-digit blanking, overflow dashes and leading-zero suppression scanned from the top digit
  always_comb begin
    seg_d = '1;
    dp_d  = '1;
    run   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run = run && !(|v_digits[4*i+:4]);
      seg_d[7*i+:7] = (!v_shown || hide[i])       ? SEG_BLANK :
                      v_ovf                       ? SEG_DASH :
                      (lzb_en && run && i != 0)   ? SEG_BLANK : font[i];
      dp_d[i] = !v_shown || hide[i] || !v_dp[i];
    end
  end

  // registered active-low outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_out <= '1;
      dp_out  <= '1;
    end else begin
      seg_out <= seg_d;
      dp_out  <= dp_d;
    end
  end
endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb_hex_display_ctrl: scoreboard bench for the 6-digit display controller
module tb_hex_display_ctrl;
  typedef struct {
    logic [41:0] seg;
    logic [5:0]  dp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [23:0] load_value = '0;
  logic        load_dec = 1'b0;
  logic [5:0]  load_dp = '0;
  logic        lzb_en = 1'b0;
  logic [5:0]  blink_mask = '0;
  logic [41:0] seg_out;
  logic [5:0]  dp_out;

  int   checks = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t last;
  logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  hex_display_ctrl #(.NUM_DIGITS(6), .BLINK_HALF(4)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_value(load_value), .load_dec(load_dec), .load_dp(load_dp),
    .lzb_en(lzb_en), .blink_mask(blink_mask), .seg_out(seg_out), .dp_out(dp_out)
  );

  function automatic logic [41:0] exp_seg(input logic [23:0] dig, input bit ovf, input bit lzb);
    logic [41:0] r;
    logic [3:0]  n;
    bit          lead;
    lead = 1'b1;
    for (int i = 5; i >= 0; i--) begin
      n = dig[4*i+:4];
      if (n != 4'd0) lead = 1'b0;
      r[7*i+:7] = ovf ? 7'h3F : (lzb && lead && i != 0) ? 7'h7F : font[n];
    end
    return r;
  endfunction

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    for (int i = 0; i < 6; i++) begin
      r[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    checks++; if (seg_out !== {42{1'b1}}) begin fails++; $display("FAIL reset_seg got %h want %h", seg_out, {42{1'b1}}); end
    checks++; if (dp_out !== 6'h3F) begin fails++; $display("FAIL reset_dp got %b want 111111", dp_out); end
    checks++; if (load_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", load_ready); end
    last.seg = '1;
    last.dp  = '1;
  endtask

  task automatic test_hex;
    exp_t e;
    load_value = 24'h00A3F1; load_dp = 6'b000100; load_dec = 1'b0; load_valid = 1'b1;
    e.seg = exp_seg(load_value, 1'b0, lzb_en); e.dp = ~load_dp; sb.push_back(e);
    tick;
    load_valid = 1'b0;
    checks++; if (load_ready !== 1'b1) begin fails++; $display("FAIL hex_ready got %b want 1", load_ready); end
    checks++; if (seg_out !== last.seg) begin fails++; $display("FAIL hex_early got %h want %h", seg_out, last.seg); end
    tick;
    checks++;
    if (sb.size() == 0) begin fails++; $display("FAIL hex_sb empty scoreboard"); end
    else begin
      e = sb.pop_front();
      if (seg_out !== e.seg || dp_out !== e.dp) begin fails++; $display("FAIL hex_out got %h/%b want %h/%b", seg_out, dp_out, e.seg, e.dp); end
      last = e;
    end
  endtask

  task automatic test_decimal(input logic [23:0] v, input logic [5:0] dp, input string nm);
    exp_t e;
    int   ival;
    ival = int'(v);
    load_value = v; load_dec = 1'b1; load_dp = dp; load_valid = 1'b1;
    e.seg = exp_seg(to_bcd(ival), ival > 999999, lzb_en); e.dp = ~dp; sb.push_back(e);
    tick;
    for (int k = 1; k <= 25; k++) begin
      load_valid = k < 24; load_dec = 1'b0; load_value = 24'($urandom); load_dp = 6'($urandom);
      checks++; if (load_ready !== 1'b0) begin fails++; $display("FAIL %s_busy cycle %0d ready got %b want 0", nm, k, load_ready); end
      checks++; if (seg_out !== last.seg || dp_out !== last.dp) begin fails++; $display("FAIL %s_hold cycle %0d got %h want %h", nm, k, seg_out, last.seg); end
      tick;
    end
    load_valid = 1'b0;
    checks++; if (load_ready !== 1'b1) begin fails++; $display("FAIL %s_ready got %b want 1", nm, load_ready); end
    checks++;
    if (sb.size() == 0) begin fails++; $display("FAIL %s_sb empty scoreboard", nm); end
    else begin
      e = sb.pop_front();
      if (seg_out !== e.seg || dp_out !== e.dp) begin fails++; $display("FAIL %s_out got %h/%b want %h/%b", nm, seg_out, dp_out, e.seg, e.dp); end
      last = e;
    end
  endtask

  task automatic test_lzb;
    exp_t e;
    lzb_en = 1'b1;
    load_value = 24'h000000; load_dp = 6'b000000; load_dec = 1'b0; load_valid = 1'b1;
    e.seg = exp_seg(load_value, 1'b0, 1'b1); e.dp = 6'h3F; sb.push_back(e);
    tick;
    load_valid = 1'b0;
    tick;
    checks++;
    if (sb.size() == 0) begin fails++; $display("FAIL lzb_sb empty scoreboard"); end
    else begin
      e = sb.pop_front();
      if (seg_out !== e.seg || dp_out !== e.dp) begin fails++; $display("FAIL lzb_on got %h/%b want %h/%b", seg_out, dp_out, e.seg, e.dp); end
    end
    lzb_en = 1'b0;
    e.seg = exp_seg(24'h0, 1'b0, 1'b0); sb.push_back(e);
    tick;
    checks++;
    if (sb.size() == 0) begin fails++; $display("FAIL lzb_off_sb empty scoreboard"); end
    else begin
      e = sb.pop_front();
      if (seg_out !== e.seg || dp_out !== e.dp) begin fails++; $display("FAIL lzb_off got %h/%b want %h/%b", seg_out, dp_out, e.seg, e.dp); end
      last = e;
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    logic [23:0] vals [3];
    logic [5:0]  dps [3];
    vals = '{24'h123456, 24'hFEDCBA, 24'h0000FF};
    dps  = '{6'b000001, 6'b100000, 6'b010101};
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        load_value = vals[k]; load_dp = dps[k]; load_dec = 1'b0; load_valid = 1'b1;
        e.seg = exp_seg(vals[k], 1'b0, lzb_en); e.dp = ~dps[k]; sb.push_back(e);
      end else load_valid = 1'b0;
      tick;
      if (k >= 1) begin
        checks++; if (load_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready %0d got %b want 1", k, load_ready); end
        checks++;
        if (sb.size() == 0) begin fails++; $display("FAIL b2b_sb %0d empty scoreboard", k); end
        else begin
          e = sb.pop_front();
          if (seg_out !== e.seg || dp_out !== e.dp) begin fails++; $display("FAIL b2b_out %0d got %h/%b want %h/%b", k, seg_out, dp_out, e.seg, e.dp); end
          last = e;
        end
      end
    end
  endtask

`ifdef HEX_DISPLAY_BLINK_EN
  task automatic test_blink;
    logic [41:0] ws;
    logic [5:0]  wd;
    logic [41:0] base;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    blink_mask = 6'b000001;
    load_value = 24'h123456; load_dp = 6'b000011; load_dec = 1'b0; load_valid = 1'b1;
    base = exp_seg(24'h123456, 1'b0, lzb_en);
    tick;
    load_valid = 1'b0;
    tick;
    for (int k = 2; k <= 20; k++) begin
      ws = base; wd = ~6'b000011;
      if ((((k - 1) / 4) % 2) != 0) begin ws[6:0] = 7'h7F; wd[0] = 1'b1; end
      checks++; if (seg_out !== ws || dp_out !== wd) begin fails++; $display("FAIL blink cycle %0d got %h/%b want %h/%b", k, seg_out, dp_out, ws, wd); end
      tick;
    end
    blink_mask = '0;
  endtask
`else
  task automatic test_blink;
    blink_mask = 6'h3F;
    for (int k = 0; k < 12; k++) begin
      tick;
      checks++; if (seg_out !== last.seg || dp_out !== last.dp) begin fails++; $display("FAIL mask_ignored cycle %0d got %h want %h", k, seg_out, last.seg); end
    end
    blink_mask = '0;
  endtask
`endif

  task automatic test_reset_mid_conv;
    load_value = 24'd654321; load_dp = 6'b111111; load_dec = 1'b1; load_valid = 1'b1;
    tick;
    load_valid = 1'b0; load_dec = 1'b0;
    repeat (9) tick;
    rst_n = 1'b0;
    tick;
    checks++; if (seg_out !== {42{1'b1}}) begin fails++; $display("FAIL midrst_seg got %h want all ones", seg_out); end
    checks++; if (dp_out !== 6'h3F) begin fails++; $display("FAIL midrst_dp got %b want 111111", dp_out); end
    checks++; if (load_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready got %b want 1", load_ready); end
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick;
      checks++; if (seg_out !== {42{1'b1}} || dp_out !== 6'h3F) begin fails++; $display("FAIL midrst_after cycle %0d got %h/%b want blank", k, seg_out, dp_out); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    test_reset;
    test_hex;
    test_decimal(24'd123456, 6'b001000, "dec");
    test_decimal(24'hFFFFFF, 6'b100001, "ovf");
    test_lzb;
    test_back_to_back;
    test_blink;
    test_reset_mid_conv;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
